// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding, address helpers and default timing for the SRAM sequencer
package sram_pkg;

  typedef enum logic [1:0] {IDLE, PRE, ACC, REC} state_t;

  localparam int DEF_ROW_BITS = 6;
  localparam int DEF_COL_SEL  = 4;
  localparam int DEF_WORD_W   = 32;
  localparam int DEF_PRE_CYC  = 1;
  localparam int DEF_ACC_CYC  = 2;

  function automatic int col_bits(input int col_sel);
    return $clog2(col_sel);
  endfunction

  // One phase counter serves both PRE and ACC, so it is sized for the longer of the two.
  function automatic int phase_w(input int pre_cyc, input int acc_cyc);
    int m;
    m = (pre_cyc > acc_cyc) ? pre_cyc : acc_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int unsigned addr_row(input int unsigned addr, input int cb);
    return addr >> cb;
  endfunction

  function automatic int unsigned addr_col(input int unsigned addr, input int cb);
    return addr & ((32'd1 << cb) - 32'd1);
  endfunction

endpackage

// File: rtl/sram_col_decoder.sv
// rtl/sram_col_decoder.sv - registered binary-to-one-hot column mux select
module sram_col_decoder #(
  parameter int COL_SEL = 4,
  parameter int CB      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [CB-1:0]      col,
  output logic [COL_SEL-1:0] col_sel
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) col_sel <= '0;
    else     col_sel <= en ? (COL_SEL'(1) << col) : '0;
  end

endmodule

// File: rtl/sram_colmux_seq.sv
// rtl/sram_colmux_seq.sv - precharge/wordline/column-mux/sense sequencer for the 64x128 SRAM macro
module sram_colmux_seq
  import sram_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int COL_SEL  = DEF_COL_SEL,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int PRE_CYC  = DEF_PRE_CYC,
  parameter int ACC_CYC  = DEF_ACC_CYC,
  parameter int CB       = col_bits(COL_SEL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ROW_BITS+CB-1:0] req_addr,
  input  logic [WORD_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [WORD_W-1:0]      rsp_rdata,
  output logic                   precharge_en,
  output logic [ROW_BITS-1:0]    wl_addr,
  output logic                   wl_en,
  output logic [COL_SEL-1:0]     col_sel,
  output logic                   write_en,
  output logic [WORD_W-1:0]      wdata_drv,
  output logic                   sense_en,
  input  logic [WORD_W-1:0]      bl_rdata
);

  localparam int AW = ROW_BITS + CB;
  localparam int PW = phase_w(PRE_CYC, ACC_CYC);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_CYC - 1);
  localparam logic [PW-1:0] ACC_LAST = PW'(ACC_CYC - 1);

  state_t              state, state_n;
  logic [PW-1:0]       phase, phase_n;
  logic [AW-1:0]       addr_q, addr_n;
  logic                we_q, we_n;
  logic [WORD_W-1:0]   wdata_q, wdata_n;
  logic [ROW_BITS-1:0] row_n;
  logic [CB-1:0]       col_n;
  logic                busy_n, acc_n;

  always_comb begin
    state_n = state;
    phase_n = phase;
    addr_n  = addr_q;
    we_n    = we_q;
    wdata_n = wdata_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_n = PRE;
          phase_n = '0;
          addr_n  = req_addr;
          we_n    = req_we;
          wdata_n = req_wdata;
        end
      end
      PRE: begin
        if (phase == PRE_LAST) begin
          state_n = ACC;
          phase_n = '0;
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      ACC: begin
        if (phase == ACC_LAST) begin
          state_n = REC;
          phase_n = '0;
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      REC:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Every array control is registered from next-state values, so it lines up with the state it belongs to.
  assign busy_n = (state_n != IDLE);
  assign acc_n  = (state_n == ACC);
  assign row_n  = ROW_BITS'(addr_row(32'(addr_n), CB));
  assign col_n  = CB'(addr_col(32'(addr_n), CB));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      precharge_en <= 1'b0;
      wl_en        <= 1'b0;
      wl_addr      <= '0;
      sense_en     <= 1'b0;
      write_en     <= 1'b0;
      wdata_drv    <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      addr_q       <= addr_n;
      we_q         <= we_n;
      wdata_q      <= wdata_n;
      precharge_en <= (state_n == PRE);
      wl_en        <= acc_n;
      wl_addr      <= acc_n ? row_n : '0;
      sense_en     <= acc_n && (phase_n == ACC_LAST) && !we_n;
      write_en     <= busy_n && we_n;
      wdata_drv    <= (busy_n && we_n) ? wdata_n : '0;
      rsp_valid    <= (state_n == REC);
      if (state == ACC && state_n == REC && !we_q)
        rsp_rdata <= bl_rdata;
    end
  end

  assign req_ready = (state == IDLE);

  sram_col_decoder #(
    .COL_SEL (COL_SEL),
    .CB      (CB)
  ) u_col_decoder (
    .clk     (clk),
    .rst     (rst),
    .en      (acc_n),
    .col     (col_n),
    .col_sel (col_sel)
  );

endmodule

// File: tb/tb_sram_colmux_seq.sv
// tb/tb_sram_colmux_seq.sv - self-checking bench for sram_colmux_seq with array and scoreboard models
module tb_sram_colmux_seq;

  localparam int P = 1;
  localparam int A = 2;
  localparam int L = P + A + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata, rsp_rdata, wdata_drv, bl_rdata;
  logic        rsp_valid, precharge_en, wl_en, write_en, sense_en;
  logic [5:0]  wl_addr;
  logic [3:0]  col_sel;

  logic        req_valid2, req_ready2, req_we2;
  logic [7:0]  req_addr2;
  logic [31:0] req_wdata2, rsp_rdata2, wdata_drv2, bl_rdata2;
  logic        rsp_valid2, precharge_en2, wl_en2, write_en2, sense_en2;
  logic [5:0]  wl_addr2;
  logic [3:0]  col_sel2;

  logic [31:0] arr  [256];
  logic [31:0] refm [256];
  logic [31:0] last_rd;
  logic [3:0]  prev_col;
  logic        prev_we;
  int          cyc, n_checks, n_pass;

  always #5 clk = ~clk;

  sram_colmux_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .precharge_en(precharge_en), .wl_addr(wl_addr), .wl_en(wl_en), .col_sel(col_sel),
    .write_en(write_en), .wdata_drv(wdata_drv), .sense_en(sense_en), .bl_rdata(bl_rdata)
  );

  sram_colmux_seq #(.PRE_CYC(3), .ACC_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .precharge_en(precharge_en2), .wl_addr(wl_addr2), .wl_en(wl_en2), .col_sel(col_sel2),
    .write_en(write_en2), .wdata_drv(wdata_drv2), .sense_en(sense_en2), .bl_rdata(bl_rdata2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int oh2bin(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // One clock: behave as the macro (sense/write through the selected column), then check invariants.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sense_en) bl_rdata = arr[{wl_addr, 2'(oh2bin(col_sel))}];
    else          bl_rdata = $urandom;
    if (wl_en && write_en && col_sel != 4'b0) arr[{wl_addr, 2'(oh2bin(col_sel))}] = wdata_drv;
    bl_rdata2 = sense_en2 ? 32'hC0FFEE11 : $urandom;
    chk("inv_onehot",   64'($onehot0(col_sel)), 64'(1));
    chk("inv_col_wl",   64'((col_sel == 4'b0) || wl_en), 64'(1));
    chk("inv_pre_wl",   64'(!(precharge_en && wl_en)), 64'(1));
    chk("inv_we_flip",  64'((write_en == prev_we) || (col_sel == 4'b0 && prev_col == 4'b0)), 64'(1));
    chk("inv_sense_we", 64'(!(sense_en && write_en)), 64'(1));
    prev_col = col_sel;
    prev_we  = write_en;
  endtask

  task automatic access(input bit we, input logic [7:0] addr, input logic [31:0] wd, input bit hold);
    logic [5:0] row;
    logic [1:0] col;
    bit         in_acc;
    row = addr[7:2];
    col = addr[1:0];
    chk("ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    step();
    req_valid = hold;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 8'($urandom);
    req_wdata = $urandom;
    for (int k = 1; k <= L; k++) begin
      in_acc = (k > P) && (k <= P + A);
      chk("ready_busy", 64'(req_ready), 64'(0));
      chk("precharge",  64'(precharge_en), 64'(k <= P));
      chk("wl_en",      64'(wl_en), 64'(in_acc));
      chk("col_sel",    64'(col_sel), 64'(in_acc ? (4'b0001 << col) : 4'b0000));
      if (in_acc) chk("wl_addr", 64'(wl_addr), 64'(row));
      chk("sense_en",   64'(sense_en), 64'(!we && k == P + A));
      chk("write_en",   64'(write_en), 64'(we));
      if (we) chk("wdata_drv", 64'(wdata_drv), 64'(wd));
      chk("rsp_valid",  64'(rsp_valid), 64'(k == L));
      if (k == L) chk("rsp_rdata", 64'(rsp_rdata), 64'(we ? last_rd : refm[addr]));
      step();
    end
    if (we) refm[addr] = wd;
    else    last_rd = refm[addr];
    chk("rsp_done", 64'(rsp_valid), 64'(0));
    chk("we_clear", 64'(write_en), 64'(0));
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    prev_col = 4'b0; prev_we = 1'b0; last_rd = 32'h0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h0; req_wdata = 32'h0; bl_rdata = 32'h0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 8'h0; req_wdata2 = 32'h0; bl_rdata2 = 32'h0;
    for (int i = 0; i < 256; i++) begin
      arr[i]  = $urandom;
      refm[i] = arr[i];
    end
    arr[255] = 32'hA5A55A5A;
    refm[255] = 32'hA5A55A5A;

    #2;
    chk("rst_ready",     64'(req_ready), 64'(1));
    chk("rst_precharge", 64'(precharge_en), 64'(0));
    chk("rst_wl_en",     64'(wl_en), 64'(0));
    chk("rst_col_sel",   64'(col_sel), 64'(0));
    chk("rst_write_en",  64'(write_en), 64'(0));
    chk("rst_sense",     64'(sense_en), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rdata",     64'(rsp_rdata), 64'(0));
    chk("rst_ready2",    64'(req_ready2), 64'(1));
    step();
    rst = 1'b0;
    step();

    access(1'b1, 8'h2D, 32'hDEADBEEF, 1'b0);
    access(1'b0, 8'hFF, 32'h0, 1'b0);
    chk("rd_ff_value", 64'(rsp_rdata), 64'(32'hA5A55A5A));

    access(1'b0, 8'h2D, 32'h0, 1'b1);
    access(1'b1, 8'h10, 32'h12345678, 1'b1);
    access(1'b0, 8'hFF, 32'h0, 1'b1);
    req_valid = 1'b0;
    step();

    // Reset in the middle of a read's ACC phase.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h5A;
    step();
    req_valid = 1'b0;
    step();
    chk("pre_rst_in_acc", 64'(wl_en), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_wl_en",   64'(wl_en), 64'(0));
    chk("mid_rst_col_sel", 64'(col_sel), 64'(0));
    chk("mid_rst_sense",   64'(sense_en), 64'(0));
    chk("mid_rst_pre",     64'(precharge_en), 64'(0));
    chk("mid_rst_rsp",     64'(rsp_valid), 64'(0));
    chk("mid_rst_rdata",   64'(rsp_rdata), 64'(0));
    chk("mid_rst_ready",   64'(req_ready), 64'(1));
    step();
    rst = 1'b0;
    last_rd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
      chk("post_rst_ready",  64'(req_ready), 64'(1));
    end
    access(1'b0, 8'h5A, 32'h0, 1'b0);

    // Long-precharge, single-cycle-access instance.
    chk("d2_ready", 64'(req_ready2), 64'(1));
    req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = 8'h37;
    step();
    req_valid2 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("d2_precharge", 64'(precharge_en2), 64'(k <= 3));
      chk("d2_wl_en",     64'(wl_en2), 64'(k == 4));
      chk("d2_col_sel",   64'(col_sel2), 64'(k == 4 ? 4'b1000 : 4'b0000));
      chk("d2_sense",     64'(sense_en2), 64'(k == 4));
      chk("d2_rsp_valid", 64'(rsp_valid2), 64'(k == 5));
      if (k == 5) chk("d2_rdata", 64'(rsp_rdata2), 64'(32'hC0FFEE11));
      step();
    end
    chk("d2_ready_end", 64'(req_ready2), 64'(1));

    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        step();
        chk("gap_ready", 64'(req_ready), 64'(1));
      end
      access(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
